// File: rtl/line_fill_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : line_fill_unit_pkg
// Brief   : Shared state encoding and line/beat geometry helpers for the
//           instruction-cache line refill engine.
// Revision: 1.0
// ============================================================================
package line_fill_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_RECEIVE = 2'd2,
        ST_WRITE   = 2'd3
    } lfu_state_t;

    localparam int C_BEAT_WIDTH = 32;

    function automatic int lane_bits(input int offset_bits);
        return 8 * (2 ** offset_bits);
    endfunction

    function automatic int beats_for(input int offset_bits);
        return lane_bits(offset_bits) / C_BEAT_WIDTH;
    endfunction

    // One spare bit so the counter can reach beats_per_line without wrapping.
    function automatic int counter_bits(input int offset_bits);
        return $clog2(beats_for(offset_bits)) + 1;
    endfunction

    localparam int C_DEFAULT_OFFSET_BITS = 6;
    localparam int C_SINGLE_LANE_SIZE    = lane_bits(C_DEFAULT_OFFSET_BITS);
    localparam int C_BEATS_PER_LINE      = beats_for(C_DEFAULT_OFFSET_BITS);
    localparam int C_COUNTER_WIDTH       = counter_bits(C_DEFAULT_OFFSET_BITS);

endpackage
`default_nettype wire

// File: rtl/line_fill_unit_line_assembly_register.sv
`default_nettype none
// ============================================================================
// Module  : line_assembly_register
// Brief   : Collects 32-bit beats into one cache line using a decoded
//           per-word write enable.
// Revision: 1.0
// ============================================================================
module line_assembly_register
    import line_fill_unit_pkg::*;
#(
    parameter int LANE_BITS = C_SINGLE_LANE_SIZE,
    parameter int IDX_BITS  = C_COUNTER_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    wr_en_i,
    input  logic [IDX_BITS-1:0]     index_i,
    input  logic [C_BEAT_WIDTH-1:0] beat_i,
    output logic [LANE_BITS-1:0]    line_o
);

    localparam int C_WORDS = LANE_BITS / C_BEAT_WIDTH;

    logic [C_WORDS-1:0]      word_sel;
    logic [C_BEAT_WIDTH-1:0] words_q [C_WORDS];

    // Each word owns its register; only the word matching the beat index loads.
    for (genvar gi = 0; gi < C_WORDS; gi++) begin : g_word
        assign word_sel[gi] = wr_en_i && (index_i == IDX_BITS'(gi));

        always_ff @(posedge clk) begin
            if (reset || clear_i) begin
                words_q[gi] <= '0;
            end else if (word_sel[gi]) begin
                words_q[gi] <= beat_i;
            end
        end

        assign line_o[gi*C_BEAT_WIDTH +: C_BEAT_WIDTH] = words_q[gi];
    end

endmodule
`default_nettype wire

// File: rtl/line_fill_unit.sv
`default_nettype none
// ============================================================================
// Module  : line_fill_unit
// Brief   : I-cache refill engine: one Avalon-MM burst per miss, beats
//           assembled into a line, presented with its victim way for a cycle.
// Revision: 1.0
// ============================================================================
module line_fill_unit
    import line_fill_unit_pkg::*;
#(
    parameter int number_of_sets        = 4,
    parameter int bits_for_offset       = 6,
    parameter int log_of_number_of_sets = 2,
    parameter int address_width         = 32,
    localparam int single_lane_size     = lane_bits(bits_for_offset),
    localparam int beats_per_line       = beats_for(bits_for_offset),
    localparam int C_CNT_W              = counter_bits(bits_for_offset)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [address_width-1:0]         req_address,
    input  logic [log_of_number_of_sets-1:0] req_pos,
    output logic [address_width-1:0]         avm_address,
    output logic                             avm_read,
    output logic [C_CNT_W-1:0]               avm_burstcount,
    input  logic                             avm_waitrequest,
    input  logic [31:0]                      avm_readdata,
    input  logic                             avm_readdatavalid,
    output logic                             fill_valid,
    output logic [single_lane_size-1:0]      fill_data,
    output logic [log_of_number_of_sets-1:0] fill_pos,
    output logic [address_width-1:0]         fill_address
);

    if (bits_for_offset < 2) begin : g_cfg_offset
        $error("line_fill_unit: bits_for_offset must be at least 2");
    end
    if (number_of_sets != 2 ** log_of_number_of_sets) begin : g_cfg_ways
        $error("line_fill_unit: number_of_sets must equal 2**log_of_number_of_sets");
    end

    localparam logic [address_width-1:0] C_LINE_MASK =
        ~address_width'((64'd1 << bits_for_offset) - 64'd1);

    lfu_state_t                       state_q;
    logic [C_CNT_W-1:0]               cnt_q;
    logic [address_width-1:0]         addr_q;
    logic [log_of_number_of_sets-1:0] pos_q;
    logic                             req_ready_q;
    logic                             avm_read_q;
    logic                             fill_valid_q;

    logic w_accept;
    logic w_beat;
    logic w_last;

    assign w_accept = (state_q == ST_IDLE) && req_valid;
    assign w_beat   = (state_q == ST_RECEIVE) && avm_readdatavalid;
    assign w_last   = w_beat && (cnt_q == C_CNT_W'(beats_per_line - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            pos_q        <= '0;
            req_ready_q  <= 1'b1;
            avm_read_q   <= 1'b0;
            fill_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_q     <= ST_REQUEST;
                        req_ready_q <= 1'b0;
                        avm_read_q  <= 1'b1;
                        addr_q      <= req_address & C_LINE_MASK;
                        pos_q       <= req_pos;
                        cnt_q       <= '0;
                    end
                end
                ST_REQUEST: begin
                    // Address/burstcount come straight from addr_q, so they
                    // stay put for as long as the slave stalls.
                    if (!avm_waitrequest) begin
                        state_q    <= ST_RECEIVE;
                        avm_read_q <= 1'b0;
                    end
                end
                ST_RECEIVE: begin
                    if (avm_readdatavalid) begin
                        cnt_q <= cnt_q + C_CNT_W'(1);
                        if (w_last) begin
                            state_q      <= ST_WRITE;
                            fill_valid_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    state_q      <= ST_IDLE;
                    fill_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    line_assembly_register #(
        .LANE_BITS (single_lane_size),
        .IDX_BITS  (C_CNT_W)
    ) u_line_assembly_register (
        .clk     (clk),
        .reset   (reset),
        .clear_i (w_accept),
        .wr_en_i (w_beat),
        .index_i (cnt_q),
        .beat_i  (avm_readdata),
        .line_o  (fill_data)
    );

    assign req_ready      = req_ready_q;
    assign avm_read       = avm_read_q;
    assign avm_address    = addr_q;
    assign avm_burstcount = C_CNT_W'(beats_per_line);
    assign fill_valid     = fill_valid_q;
    assign fill_pos       = pos_q;
    assign fill_address   = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_line_fill_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_line_fill_unit
// Brief   : Self-checking bench for line_fill_unit: transaction-level model
//           compared every cycle, plus directed literal expectations.
// Revision: 1.0
// ============================================================================
module tb_line_fill_unit;

    localparam int C_LW = 512;
    localparam int C_NB = 16;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_address;
    logic [1:0]   req_pos;
    logic [31:0]  avm_address;
    logic         avm_read;
    logic [4:0]   avm_burstcount;
    logic         avm_waitrequest;
    logic [31:0]  avm_readdata;
    logic         avm_readdatavalid;
    logic         fill_valid;
    logic [C_LW-1:0] fill_data;
    logic [1:0]   fill_pos;
    logic [31:0]  fill_address;

    line_fill_unit dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_address       (req_address),
        .req_pos           (req_pos),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .fill_valid        (fill_valid),
        .fill_data         (fill_data),
        .fill_pos          (fill_pos),
        .fill_address      (fill_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [C_LW-1:0] act, input logic [C_LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        fails++;
        $display("FAIL timeout_%s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [C_LW-1:0] ramp(input logic [31:0] base);
        logic [C_LW-1:0] r;
        r = '0;
        for (int k = 0; k < C_NB; k++) r[k*32 +: 32] = base + 32'(k);
        return r;
    endfunction

    // ---------------- transaction-level reference model -------------------
    bit              m_ready = 1'b1;
    bit              m_cmd   = 1'b0;
    bit              m_rx    = 1'b0;
    bit              m_fill  = 1'b0;
    int              m_n     = 0;
    logic [31:0]     m_addr  = '0;
    logic [1:0]      m_pos   = '0;
    logic [C_LW-1:0] m_data  = '0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_ready = 1'b1; m_cmd = 1'b0; m_rx = 1'b0; m_fill = 1'b0; m_n = 0;
            m_addr = '0; m_pos = '0; m_data = '0;
        end else if (m_fill) begin
            m_fill  = 1'b0;
            m_ready = 1'b1;
        end else if (m_ready && req_valid) begin
            m_ready = 1'b0;
            m_cmd   = 1'b1;
            m_addr  = {req_address[31:6], 6'd0};
            m_pos   = req_pos;
            m_data  = '0;
            m_n     = 0;
        end else if (m_cmd && !avm_waitrequest) begin
            m_cmd = 1'b0;
            m_rx  = 1'b1;
        end else if (m_rx && avm_readdatavalid) begin
            m_data[m_n*32 +: 32] = avm_readdata;
            m_n++;
            if (m_n == C_NB) begin
                m_rx   = 1'b0;
                m_fill = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare and event monitor -----------------
    int              cmd_cnt  = 0;
    int              fill_cnt = 0;
    int              fill_cyc = 0;
    int              acc_cyc  = 0;
    logic [31:0]     last_cmd_addr;
    logic [C_LW-1:0] cap_data;
    logic [1:0]      cap_pos;
    logic [31:0]     cap_addr;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", C_LW'(req_ready), C_LW'(m_ready));
            chk("avm_read", C_LW'(avm_read), C_LW'(m_cmd));
            chk("avm_burstcount", C_LW'(avm_burstcount), C_LW'(C_NB));
            chk("fill_valid", C_LW'(fill_valid), C_LW'(m_fill));
            if (m_cmd) chk("avm_address", C_LW'(avm_address), C_LW'(m_addr));
            if (m_fill || m_ready) begin
                chk("fill_data", fill_data, m_data);
                chk("fill_pos", C_LW'(fill_pos), C_LW'(m_pos));
                chk("fill_address", C_LW'(fill_address), C_LW'(m_addr));
            end
            if (avm_read && !avm_waitrequest) begin
                cmd_cnt++;
                last_cmd_addr = avm_address;
            end
            if (fill_valid) begin
                fill_cnt++;
                fill_cyc = cyc;
                cap_data = fill_data;
                cap_pos  = fill_pos;
                cap_addr = fill_address;
            end
            if (req_valid && req_ready) acc_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] a, input logic [1:0] p);
        int n;
        req_address = a;
        req_pos     = p;
        req_valid   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) timeout("accept");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_cmd();
        int n;
        n = 0;
        @(negedge clk);
        while (!(avm_read && !avm_waitrequest) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(avm_read && !avm_waitrequest)) timeout("command");
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input int count, input logic [31:0] base, input int gapmax);
        for (int k = 0; k < count; k++) begin
            int g;
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            avm_readdatavalid = 1'b0;
            repeat (g) tick();
            avm_readdatavalid = 1'b1;
            avm_readdata      = base + 32'(k);
            tick();
        end
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
    endtask

    task automatic wait_fill();
        int n;
        n = 0;
        @(negedge clk);
        while (!fill_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!fill_valid) timeout("fill");
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence -----------------------------------
    initial begin
        int              fc0;
        int              cc0;
        logic [C_LW-1:0] d0;
        logic [1:0]      p0;

        reset = 1'b1; req_valid = 1'b0; req_address = '0; req_pos = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_req_ready", C_LW'(req_ready), C_LW'(1));
        chk("reset_avm_read", C_LW'(avm_read), C_LW'(0));
        chk("reset_fill_valid", C_LW'(fill_valid), C_LW'(0));
        chk("reset_fill_data", fill_data, '0);

        // Zero-wait miss with ramp data and minimum latency
        accept(32'h0000_1234, 2'd2);
        wait_cmd();
        chk("t1_cmd_addr", C_LW'(last_cmd_addr), C_LW'(32'h0000_1200));
        send_beats(C_NB, 32'h0, 0);
        wait_fill();
        chk("t1_data", cap_data, ramp(32'h0));
        chk("t1_pos", C_LW'(cap_pos), C_LW'(2));
        chk("t1_addr", C_LW'(cap_addr), C_LW'(32'h0000_1200));
        chk("t1_latency", C_LW'(fill_cyc - acc_cyc + 1), C_LW'(3 + C_NB));

        // Slave stalls the command for five cycles
        cc0 = cmd_cnt;
        fc0 = fill_cnt;
        avm_waitrequest = 1'b1;
        accept(32'h8000_0047, 2'd1);
        repeat (5) tick();
        avm_waitrequest = 1'b0;
        wait_cmd();
        send_beats(C_NB, 32'h0000_0100, 0);
        wait_fill();
        chk("t2_one_command", C_LW'(cmd_cnt - cc0), C_LW'(1));
        chk("t2_cmd_addr", C_LW'(last_cmd_addr), C_LW'(32'h8000_0040));
        chk("t2_one_fill", C_LW'(fill_cnt - fc0), C_LW'(1));

        // Random gaps between beats
        fc0 = fill_cnt;
        accept(32'h0000_3FFC, 2'd0);
        wait_cmd();
        send_beats(C_NB, 32'hA5A5_0000, 3);
        wait_fill();
        repeat (5) tick();
        chk("t3_data", cap_data, ramp(32'hA5A5_0000));
        chk("t3_one_fill", C_LW'(fill_cnt - fc0), C_LW'(1));

        // New request held during RECEIVE is accepted only at L+2
        accept(32'h0000_1000, 2'd1);
        req_address = 32'h0000_2044;
        req_pos     = 2'd3;
        req_valid   = 1'b1;
        wait_cmd();
        send_beats(C_NB, 32'h0000_0200, 1);
        wait_fill();
        accept(32'h0000_2044, 2'd3);
        chk("t4_accept_cycle", C_LW'(acc_cyc), C_LW'(fill_cyc + 1));
        wait_cmd();
        chk("t4_cmd_addr", C_LW'(last_cmd_addr), C_LW'(32'h0000_2040));
        send_beats(C_NB, 32'h0000_0300, 0);
        wait_fill();
        chk("t4_pos", C_LW'(cap_pos), C_LW'(3));
        chk("t4_addr", C_LW'(cap_addr), C_LW'(32'h0000_2040));
        chk("t4_data", cap_data, ramp(32'h0000_0300));

        // Reset mid-burst, stray beats afterwards
        fc0 = fill_cnt;
        accept(32'h5555_5580, 2'd2);
        wait_cmd();
        send_beats(8, 32'h0000_0400, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_beats(8, 32'h0000_0408, 0);
        repeat (3) tick();
        chk("t5_no_fill", C_LW'(fill_cnt - fc0), C_LW'(0));
        chk("t5_data_zero", fill_data, '0);
        chk("t5_addr_zero", C_LW'(fill_address), C_LW'(0));
        accept(32'h0000_0700, 2'd1);
        wait_cmd();
        send_beats(C_NB, 32'h0000_0500, 0);
        wait_fill();
        chk("t5_refill_data", cap_data, ramp(32'h0000_0500));
        chk("t5_refill_addr", C_LW'(cap_addr), C_LW'(32'h0000_0700));

        // Back-to-back misses to ways 0 and 3
        fc0 = fill_cnt;
        accept(32'h0000_0A00, 2'd0);
        wait_cmd();
        send_beats(C_NB, 32'h0000_1000, 0);
        wait_fill();
        d0 = cap_data;
        p0 = cap_pos;
        accept(32'h0000_0B00, 2'd3);
        wait_cmd();
        send_beats(C_NB, 32'h0000_2000, 0);
        wait_fill();
        chk("t6_first_pos", C_LW'(p0), C_LW'(0));
        chk("t6_first_data", d0, ramp(32'h0000_1000));
        chk("t6_second_pos", C_LW'(cap_pos), C_LW'(3));
        chk("t6_second_data", cap_data, ramp(32'h0000_2000));
        chk("t6_two_fills", C_LW'(fill_cnt - fc0), C_LW'(2));

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_fill_unit.md
# line_fill_unit

Refill engine for the instruction cache. On a miss it issues one Avalon-MM burst read for the missing line, assembles the returned 32-bit beats into a full line, then presents that line and its victim way for one cycle. The cache writes the line into the data lane through update_data_lane. It sits between the miss-detection logic and the memory-side Avalon master port.

## Interface
- number_of_sets, 4, ways per cache set
- bits_for_offset, 6, byte-offset bits per line (line = 64 B); must be ≥ 2
- log_of_number_of_sets, 2, width of way index
- address_width, 32, byte address width
- single_lane_size, 8*(2**bits_for_offset), line width in bits
- beats_per_line, single_lane_size/32, 32-bit beats per line
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  miss request
- req_ready  out  1  high when idle, i.e. a request can be accepted
- req_address  in  address_width  miss byte address
- req_pos  in  log_of_number_of_sets  victim way
- avm_address  out  address_width  line-aligned burst address
- avm_read  out  1  burst read command
- avm_burstcount  out  log2(beats_per_line)+1  constant beats_per_line
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  returned beat
- avm_readdatavalid  in  1  beat valid
- fill_valid  out  1  one-cycle strobe: fill_data/fill_pos valid
- fill_data  out  single_lane_size  assembled line
- fill_pos  out  log_of_number_of_sets  victim way, latched at accept
- fill_address  out  address_width  line-aligned address of the filled line

## Operation
- States: IDLE, REQUEST, RECEIVE, WRITE.
- IDLE: req_ready=1. If req_valid, latch address (low bits_for_offset bits zeroed) and req_pos, clear the beat counter, go to REQUEST.
- REQUEST: avm_read=1, avm_address=latched address, avm_burstcount=beats_per_line. Address and burstcount are held stable while avm_waitrequest=1. On the cycle with avm_waitrequest=0, the command is accepted: go to RECEIVE.
- RECEIVE: each avm_readdatavalid beat k (k = 0…beats_per_line-1) is written to fill_data[k*32 +: 32] and the counter increments. On the last beat, go to WRITE.
- WRITE: fill_valid=1 for exactly one cycle, then go to IDLE.
- avm_readdatavalid is ignored outside RECEIVE. A beat arriving in the same cycle the command is accepted is not possible under Avalon and is not handled.
- fill_data, fill_pos and fill_address hold their values after WRITE until the next accept.
- Beat counter is log2(beats_per_line)+1 bits wide; it never wraps within a burst.
- Reset in any state:
  - next state IDLE; counter cleared;
  - avm_read=0, fill_valid=0, fill_data/fill_pos/fill_address=0;
  - an abandoned burst's remaining beats arriving in IDLE are discarded.
- Reset values: req_ready=1 after the reset cycle; all other outputs 0; avm_burstcount is the constant beats_per_line.

## Timing
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Accept at edge T → avm_read high from cycle T+1.
- Command accepted at edge C → RECEIVE from C+1.
- Last beat sampled at edge L → fill_valid high in cycle L+1 only → req_ready high in cycle L+2.
- Minimum request-to-fill: 3 + beats_per_line cycles with zero wait states and back-to-back beats.
- Gaps between beats are allowed and only stretch RECEIVE.
- req_valid while req_ready=0 is ignored; the requester holds req_valid until accepted.

## Structure
- Shared package: state enum (IDLE/REQUEST/RECEIVE/WRITE), derived constants single_lane_size, beats_per_line and counter width.
- One sub-module: line_assembly_register.
  - Inputs: beat, beat index, write enable, clear.
  - Output: single_lane_size line.
  - Write: decoded per-word enable, the dual of update_data_lane's per-way select.

## Test plan
- Miss at 0x0000_1234, pos=2, zero wait, beats 0x00..0x0F → avm_address=0x0000_1200, burstcount=16; fill_valid one cycle at L+1; fill_data word k = k; fill_pos=2; fill_address=0x0000_1200.
- avm_waitrequest held 5 cycles in REQUEST → avm_address and avm_read stable throughout; exactly one command accepted.
- Beats with random 0–3 cycle gaps, values 0xA5A5_0000+k → correct word order; fill_valid exactly once.
- req_valid held high during RECEIVE with a different address → ignored; accepted only in cycle L+2; second burst uses the new address.
- Reset asserted after beat 7, then 8 stray beats in IDLE → fill_valid never asserts; fill_data=0; next miss fills correctly.
- Back-to-back misses to pos 0 then pos 3 → two fill_valid pulses, each with the correct pos and line; no beat leaks between lines.
